tm_load_sequencer: RTL



---
 rtl/tm_load_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tm_load_sequencer.sv
// Load/run sequencer for a small Turing-machine datapath: loads tape cells and
// transition rules from user switches, then paces the machine with step pulses.
module tm_load_sequencer #(
  parameter int TAPE_LEN  = 128,
  parameter int NUM_RULES = 32,
  parameter int STEP_DIV  = 4,
  parameter int MAX_STEPS = 1023,
  localparam int TA_W = (TAPE_LEN  > 1) ? $clog2(TAPE_LEN)  : 1,
  localparam int RA_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            next_in,
  input  logic            done_in,
  input  logic [6:0]      data_in,
  input  logic            halt_in,
  output logic            tape_we,
  output logic [TA_W-1:0] tape_addr,
  output logic            rule_we,
  output logic [RA_W-1:0] rule_addr,
  output logic [6:0]      wdata,
  output logic            step,
  output logic [2:0]      phase,
  output logic            timeout,
  output logic            overflow
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TA_W-1:0]  TA_LAST  = TA_W'(TAPE_LEN - 1);
  localparam logic [RA_W-1:0]  RA_LAST  = RA_W'(NUM_RULES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [9:0]       STEP_MAX = 10'(MAX_STEPS);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_TAPE  = 3'd1,
    PH_RULES = 3'd2,
    PH_RUN   = 3'd3,
    PH_DONE  = 3'd4
  } phase_t;

  phase_t           r_phase, w_phase;
  logic             r_next_prev, r_done_prev;
  logic [TA_W-1:0]  r_tape_addr, w_tape_addr;
  logic [RA_W-1:0]  r_rule_addr, w_rule_addr;
  logic             r_tape_full, w_tape_full;
  logic             r_rule_full, w_rule_full;
  logic             r_tape_we, w_tape_we;
  logic             r_rule_we, w_rule_we;
  logic [6:0]       r_wdata, w_wdata;
  logic             r_step, w_step;
  logic             r_timeout, w_timeout;
  logic             r_overflow, w_overflow;
  logic [DIV_W-1:0] r_div, w_div;
  logic [9:0]       r_steps, w_steps;
  logic             w_next_ev, w_done_ev;

  assign w_next_ev = next_in & ~r_next_prev;
  assign w_done_ev = done_in & ~r_done_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase     <= PH_IDLE;
      r_next_prev <= 1'b0;
      r_done_prev <= 1'b0;
      r_tape_addr <= '0;
      r_rule_addr <= '0;
      r_tape_full <= 1'b0;
      r_rule_full <= 1'b0;
      r_tape_we   <= 1'b0;
      r_rule_we   <= 1'b0;
      r_wdata     <= '0;
      r_step      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_div       <= '0;
      r_steps     <= '0;
    end else begin
      r_phase     <= w_phase;
      r_next_prev <= next_in;
      r_done_prev <= done_in;
      r_tape_addr <= w_tape_addr;
      r_rule_addr <= w_rule_addr;
      r_tape_full <= w_tape_full;
      r_rule_full <= w_rule_full;
      r_tape_we   <= w_tape_we;
      r_rule_we   <= w_rule_we;
      r_wdata     <= w_wdata;
      r_step      <= w_step;
      r_timeout   <= w_timeout;
      r_overflow  <= w_overflow;
      r_div       <= w_div;
      r_steps     <= w_steps;
    end
  end

  always_comb begin
    w_phase     = r_phase;
    w_tape_addr = r_tape_addr;
    w_rule_addr = r_rule_addr;
    w_tape_full = r_tape_full;
    w_rule_full = r_rule_full;
    w_tape_we   = 1'b0;
    w_rule_we   = 1'b0;
    w_wdata     = r_wdata;
    w_step      = 1'b0;
    w_timeout   = r_timeout;
    w_overflow  = r_overflow;
    w_div       = r_div;
    w_steps     = r_steps;

    // Address advances the cycle after its strobe; the full flag marks that
    // the last slot has been written so the saturated address is not reused.
    if (r_tape_we) begin
      if (r_tape_addr == TA_LAST) w_tape_full = 1'b1;
      else                        w_tape_addr = r_tape_addr + TA_W'(1);
    end
    if (r_rule_we) begin
      if (r_rule_addr == RA_LAST) w_rule_full = 1'b1;
      else                        w_rule_addr = r_rule_addr + RA_W'(1);
    end

    case (r_phase)
      PH_IDLE: begin
        if (w_done_ev) begin
          w_phase     = PH_TAPE;
          w_tape_addr = '0;
          w_tape_full = 1'b0;
        end
      end
      PH_TAPE: begin
        if (w_done_ev) begin
          w_phase     = PH_RULES;
          w_rule_addr = '0;
          w_rule_full = 1'b0;
          w_overflow  = 1'b0;
        end else if (w_next_ev) begin
          if (r_tape_full) begin
            w_overflow = 1'b1;
          end else begin
            w_tape_we = 1'b1;
            w_wdata   = data_in;
          end
        end
      end
      PH_RULES: begin
        if (w_done_ev) begin
          w_phase    = PH_RUN;
          w_div      = '0;
          w_steps    = '0;
          w_overflow = 1'b0;
        end else if (w_next_ev) begin
          if (r_rule_full) begin
            w_overflow = 1'b1;
          end else begin
            w_rule_we = 1'b1;
            w_wdata   = data_in;
          end
        end
      end
      PH_RUN: begin
        // halt_in outranks both the budget check and a step that is due
        if (halt_in) begin
          w_phase = PH_DONE;
        end else if (r_steps == STEP_MAX) begin
          w_phase   = PH_DONE;
          w_timeout = 1'b1;
        end else if (r_div == DIV_LAST) begin
          w_div   = '0;
          w_step  = 1'b1;
          w_steps = r_steps + 10'd1;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end
      PH_DONE: begin
        if (w_done_ev) begin
          w_phase     = PH_IDLE;
          w_timeout   = 1'b0;
          w_overflow  = 1'b0;
          w_tape_addr = '0;
          w_rule_addr = '0;
          w_tape_full = 1'b0;
          w_rule_full = 1'b0;
          w_div       = '0;
          w_steps     = '0;
        end
      end
      default: w_phase = PH_IDLE;
    endcase
  end

  assign tape_we   = r_tape_we;
  assign tape_addr = r_tape_addr;
  assign rule_we   = r_rule_we;
  assign rule_addr = r_rule_addr;
  assign wdata     = r_wdata;
  assign step      = r_step;
  assign phase     = r_phase;
  assign timeout   = r_timeout;
  assign overflow  = r_overflow;

endmodule
